// File: rtl/regf_sb.sv
// Integer register file with a per-register pending-write scoreboard and optional writeback bypass.
// Reads and stall are combinational (0 cycles); writes and scoreboard updates land on the next edge.
module regf_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [AW-1:0]       rs1_addr,
  input  logic [AW-1:0]       rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                iss_valid,
  input  logic                iss_rs1_used,
  input  logic                iss_rs2_used,
  input  logic                iss_rd_we,
  input  logic [AW-1:0]       iss_rd,
  output logic                stall,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [(2**AW)-1:0]  busy
);
  localparam int NREG = 2**AW;

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] wb_dec;
  logic [NREG-1:0] set_dec;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] busy_n;
  logic            fwd_en;
  logic            fire;

  // Forwarding is gated by reset so reads stay 0 while rstn is low.
  assign fwd_en = (BYPASS != 0) && wb_en && rstn;

  always_comb begin
    wb_dec = '0;
    if (wb_en) wb_dec[wb_addr] = 1'b1;
  end

  assign eff_busy = fwd_en ? (busy_q & ~wb_dec) : busy_q;

  assign stall = iss_valid & ((iss_rs1_used & eff_busy[rs1_addr]) |
                              (iss_rs2_used & eff_busy[rs2_addr]) |
                              (iss_rd_we    & eff_busy[iss_rd]));
  assign fire  = iss_valid & ~stall;

  always_comb begin
    set_dec = '0;
    if (fire && iss_rd_we) set_dec[iss_rd] = 1'b1;
  end

  // Set is applied after clear so a same-edge issue to the written register keeps it pending.
  assign busy_n = ((busy_q & ~wb_dec) | set_dec) & {{(NREG-1){1'b1}}, 1'b0};

  always_comb begin
    rs1_data = mem[rs1_addr];
    if (fwd_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if (rs1_addr == '0) rs1_data = '0;
  end

  always_comb begin
    rs2_data = mem[rs2_addr];
    if (fwd_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
    if (rs2_addr == '0) rs2_data = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_n;
  end

  assign busy = busy_q;
endmodule
